lsu_rmw: RTL and testbench

- Load/store unit sitting directly upstream of dmem. dmem has a combinational read, a synchronous word write and no byte enables.
- Accepts one memory request at a time from the MEM stage and presents word-aligned accesses to dmem.
- Performs sign/zero extension for sub-word loads.
- Implements sb/sh as a single-cycle read-modify-write over the word port.
- Flags misaligned or illegal requests without touching memory.

---
 rtl/lsu_rmw_if.sv | 26 ++
 rtl/lsu_rmw.sv | 117 +++++++++++
 tb/tb_lsu_rmw.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_rmw_if.sv
// Request/response and dmem bus of the load/store unit.
// slave = the LSU; master = MEM stage plus dmem.
interface lsu_rmw_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_a;
    logic [31:0]       dmem_wd;
    logic [31:0]       dmem_rd;

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata, dmem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, dmem_we, dmem_a, dmem_wd
    );
    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata, dmem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, dmem_we, dmem_a, dmem_wd
    );
endinterface

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only dmem: sub-word loads are extended,
// sb/sh become a single-cycle read-modify-write, and bad requests never touch memory.
module lsu_rmw #(parameter int ADDR_W = 32) (
    input  logic       clk,
    input  logic       reset,
    lsu_rmw_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state;
    logic              r_we;
    logic [2:0]        r_op;
    logic [1:0]        r_lane;
    logic [31:0]       r_wdata;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic [ADDR_W-1:0] r_dmem_a;
    logic [31:0]       r_dmem_wd;

    logic              w_illegal;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ld_data;
    logic [31:0]       w_st_data;

    always_comb begin
        w_illegal = 1'b0;
        if (bus.req_we) begin
            case (bus.req_op[1:0])
                2'b01:   w_illegal = bus.req_addr[0];
                2'b10:   w_illegal = |bus.req_addr[1:0];
                2'b11:   w_illegal = 1'b1;
                default: w_illegal = 1'b0;
            endcase
        end else begin
            case (bus.req_op)
                3'b000, 3'b100: w_illegal = 1'b0;
                3'b001, 3'b101: w_illegal = bus.req_addr[0];
                3'b010:         w_illegal = |bus.req_addr[1:0];
                default:        w_illegal = 1'b1;
            endcase
        end
    end

    // Lane extraction and merge both work on the live dmem read of the ACCESS cycle.
    always_comb begin
        w_byte    = bus.dmem_rd[{r_lane, 3'b000} +: 8];
        w_half    = bus.dmem_rd[{r_lane[1], 4'b0000} +: 16];
        w_ld_data = bus.dmem_rd;
        case (r_op)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = bus.dmem_rd;
        endcase
        w_st_data = bus.dmem_rd;
        case (r_op[1:0])
            2'b00:   w_st_data[{r_lane, 3'b000} +: 8]     = r_wdata[7:0];
            2'b01:   w_st_data[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_st_data = r_wdata;
        endcase
    end

    assign bus.req_ready  = (r_state == IDLE) && !reset;
    assign bus.dmem_we    = (r_state == ACCESS) && r_we && !reset;
    assign bus.dmem_a     = r_dmem_a;
    assign bus.dmem_wd    = ((r_state == ACCESS) && r_we) ? w_st_data : r_dmem_wd;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_op         <= 3'd0;
            r_lane       <= 2'd0;
            r_wdata      <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_dmem_a     <= '0;
            r_dmem_wd    <= 32'd0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we       <= bus.req_we;
                        r_op       <= bus.req_op;
                        r_lane     <= bus.req_addr[1:0];
                        r_wdata    <= bus.req_wdata;
                        r_resp_err <= w_illegal;
                        if (w_illegal) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= 32'd0;
                        end else begin
                            r_state  <= ACCESS;
                            r_dmem_a <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                ACCESS: begin
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= r_we ? 32'd0 : w_ld_data;
                    if (r_we) r_dmem_wd <= w_st_data;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw: a word-level reference memory predicts every
// response, dmem write and access address; literals pin the headline values.
module tb_lsu_rmw;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic preload = 1'b1;
    always #5 clk = ~clk;

    lsu_rmw_if #(.ADDR_W(32)) bus();
    lsu_rmw #(.ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    function automatic logic [31:0] init_word(int i);
        return (i == 1) ? 32'h8899AABB : 32'h01010101 * i;
    endfunction

    assign bus.dmem_rd = mem[bus.dmem_a[7:2]];
    always @(posedge clk) begin
        if (preload) for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        else if (bus.dmem_we) mem[bus.dmem_a[7:2]] <= bus.dmem_wd;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        string       nm;
        int          acyc;
        int          wecyc;
        int          due;
        bit          err;
        logic [31:0] rdata;
        logic [31:0] aa;
        logic [31:0] wd;
        bit          lit;
        logic [31:0] litv;
    } exp_t;
    exp_t exp_q[$];
    bit mon_en = 1'b0;

    always @(negedge clk) begin
        bit ev, ew;
        if (mon_en) begin
            ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            ew = (exp_q.size() > 0) && (exp_q[0].wecyc == cyc);
            chk("resp_valid", {31'd0, bus.resp_valid}, {31'd0, ev});
            chk("dmem_we", {31'd0, bus.dmem_we}, {31'd0, ew});
            chk("dmem_a low bits", {30'd0, bus.dmem_a[1:0]}, 32'd0);
            if (exp_q.size() > 0 && exp_q[0].acyc == cyc)
                chk({exp_q[0].nm, " dmem_a"}, bus.dmem_a, exp_q[0].aa);
            if (ew) chk({exp_q[0].nm, " dmem_wd"}, bus.dmem_wd, exp_q[0].wd);
            if (ev) begin
                chk({exp_q[0].nm, " resp_err"}, {31'd0, bus.resp_err}, {31'd0, exp_q[0].err});
                chk({exp_q[0].nm, " resp_rdata"}, bus.resp_rdata, exp_q[0].rdata);
                if (exp_q[0].lit) chk({exp_q[0].nm, " literal"}, bus.resp_rdata, exp_q[0].litv);
                void'(exp_q.pop_front());
            end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                void'(exp_q.pop_front());
            end
        end
    end

    // Reference behaviour: legality from size/alignment, data via shifts and masks.
    task automatic model(input bit we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, output bit err, output logic [31:0] rd,
                         output logic [31:0] nw);
        int size, sh, idx;
        bit ok;
        logic [31:0] w, v, mask;
        size = int'(op[1:0]);
        ok = we ? (size != 3) : (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5);
        ok = ok && ((addr % (32'd1 << size)) == 0);
        err = !ok;
        rd = 32'd0;
        nw = 32'd0;
        idx = int'(addr[7:2]);
        sh = 8 * int'(addr % 4);
        w = ref_mem[idx];
        mask = (size == 0) ? 32'hFF : (size == 1) ? 32'hFFFF : 32'hFFFFFFFF;
        if (ok && !we) begin
            v = (w >> sh) & mask;
            if (!op[2] && size == 0 && v[7]) v = v | 32'hFFFFFF00;
            if (!op[2] && size == 1 && v[15]) v = v | 32'hFFFF0000;
            rd = v;
        end else if (ok && we) begin
            nw = (w & ~(mask << sh)) | ((wd << sh) & (mask << sh));
            ref_mem[idx] = nw;
        end
    endtask

    // Caller is at a negedge; returns at the negedge of the response cycle.
    task automatic send(input bit we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input bit lit, input logic [31:0] litv,
                        input string nm, output int acc);
        int n;
        exp_t e;
        bit err;
        logic [31:0] rd, nw;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL %s accept: req_ready never rose within 20 cycles", nm);
            bus.req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        model(we, op, addr, wd, err, rd, nw);
        e.nm    = nm;
        e.err   = err;
        e.rdata = rd;
        e.aa    = {addr[31:2], 2'b00};
        e.wd    = nw;
        e.lit   = lit;
        e.litv  = litv;
        e.acyc  = err ? -1 : acc;
        e.wecyc = (!err && we) ? acc : -1;
        e.due   = err ? acc : acc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (cyc < e.due) @(negedge clk);
    endtask

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a1, a2, n;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("reset resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("reset resp_rdata", bus.resp_rdata, 32'd0);
        chk("reset dmem_a", bus.dmem_a, 32'd0);
        chk("reset dmem_wd", bus.dmem_wd, 32'd0);
        chk("reset dmem_we", {31'd0, bus.dmem_we}, 32'd0);
        chk("reset req_ready", {31'd0, bus.req_ready}, 32'd0);
        reset = 1'b0;
        preload = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        send(0, LW,  32'h4, 32'h0, 1, 32'h8899AABB, "lw 0x4", a);
        send(0, LB,  32'h5, 32'h0, 1, 32'hFFFFFFAA, "lb 0x5", a);
        send(0, LBU, 32'h5, 32'h0, 1, 32'h000000AA, "lbu 0x5", a);
        send(0, LH,  32'h6, 32'h0, 1, 32'hFFFF8899, "lh 0x6", a);
        send(0, LHU, 32'h6, 32'h0, 1, 32'h00008899, "lhu 0x6", a);
        send(0, LB,  32'h4, 32'h0, 1, 32'hFFFFFFBB, "lb 0x4", a);

        send(1, SB, 32'h7, 32'h12345655, 1, 32'h0, "sb 0x7", a);
        send(0, LW, 32'h4, 32'h0, 1, 32'h5599AABB, "lw after sb", a);
        send(1, SH, 32'h4, 32'h0000CAFE, 1, 32'h0, "sh 0x4", a);
        send(0, LW, 32'h4, 32'h0, 1, 32'h5599CAFE, "lw after sh", a);

        send(1, SW, 32'h8, 32'h00000001, 1, 32'h0, "sw 0x8", a1);
        send(0, LW, 32'h8, 32'h0, 1, 32'h00000001, "lw 0x8", a2);
        chk("back-to-back accept cycle", a2, a1 + 3);

        send(0, LW, 32'h6, 32'h0, 1, 32'h0, "lw 0x6 misaligned", a);
        send(1, SH, 32'h3, 32'hFFFF, 1, 32'h0, "sh 0x3 misaligned", a);
        send(0, 3'b011, 32'h4, 32'h0, 1, 32'h0, "load op 011", a);
        send(1, 3'b011, 32'h8, 32'h0, 1, 32'h0, "store op 11", a);
        send(0, LHU, 32'hA, 32'h0, 0, 32'h0, "lhu 0xA", a);

        // sb to 0x4 abandoned by a reset raised during its ACCESS cycle
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_op    = SB;
        bus.req_addr  = 32'h4;
        bus.req_wdata = 32'h00000077;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reset-test accept", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("reset in ACCESS dmem_we", {31'd0, bus.dmem_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("req_ready after reset", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        chk("no resp after reset", {31'd0, bus.resp_valid}, 32'd0);
        send(0, LW, 32'h4, 32'h0, 1, 32'h5599CAFE, "lw after reset", a);

        repeat (2) @(negedge clk);
        for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
